multiplier_mac: RTL and testbench

Sequential shift-add multiply-accumulate unit, the parametrised successor to the fixed-width 4-bit multiplier. It multiplies N-bit operands in signed or unsigned mode and skips cycles once the remaining multiplier bits are zero. A guarded accumulator can keep a running sum of products. Valid/ready handshakes on input and output let it sit between streaming producers and consumers in the datapath.

---
 rtl/multiplier_pkg.sv | 31 +++
 rtl/multiplier_mac_accumulator.sv | 45 ++++
 rtl/multiplier_mac.sv | 114 +++++++++++
 tb/tb_multiplier_mac.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the shift-add multiply-accumulate unit.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int G_DEFAULT = 4;
  localparam int MAX_W     = 64;

  typedef struct packed {
    logic             neg;
    logic [MAX_W-1:0] mag;
  } mag_sign_t;

  // Magnitude is returned unsigned, so -2^(width-1) maps to 2^(width-1) without overflow.
  function automatic mag_sign_t operand_mag(input logic [MAX_W-1:0] value,
                                            input int               width,
                                            input logic             is_signed);
    mag_sign_t        r;
    logic [MAX_W-1:0] mask;
    mask  = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    r.neg = is_signed & value[width-1];
    r.mag = r.neg ? ((~value + MAX_W'(1)) & mask) : (value & mask);
    return r;
  endfunction

endpackage

// File: rtl/multiplier_mac_accumulator.sv
// Guarded accumulator: extends each finished product, then loads or adds it, with sticky overflow.
module multiplier_mac_accumulator
  import multiplier_pkg::*;
#(
  parameter int N = 8,
  parameter int G = G_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fix_strobe,
  input  logic                 op_signed,
  input  logic                 op_accumulate,
  input  logic [2*N-1:0]       product,
  output logic [2*N+G-1:0]     acc,
  output logic                 acc_overflow
);

  localparam int ACC_W = 2*N + G;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;

  always_comb begin
    ext     = op_signed ? {{G{product[2*N-1]}}, product} : {{G{1'b0}}, product};
    sum     = acc + ext;
    add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc          <= '0;
      acc_overflow <= 1'b0;
    end else if (fix_strobe) begin
      if (op_accumulate) begin
        acc          <= sum;
        acc_overflow <= acc_overflow | add_ovf;
      end else begin
        acc          <= ext;
        acc_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multiplier_mac.sv
// Sequential shift-add multiplier with early exit on exhausted multiplier bits,
// feeding a guarded accumulator, with valid/ready handshakes on both sides.
module multiplier_mac
  import multiplier_pkg::*;
#(
  parameter int N = 8,
  parameter int G = G_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         multiplicand,
  input  logic [N-1:0]         multiplier,
  input  logic                 op_signed,
  input  logic                 op_accumulate,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N-1:0]       product,
  output logic [2*N+G-1:0]     acc,
  output logic                 acc_overflow
);

  localparam int STEP_W = $clog2(N + 1);

  state_t            state, state_next;
  logic [N-1:0]      mcand_q, mplier_q;
  logic [2*N-1:0]    partial_q, fix_product;
  logic [STEP_W-1:0] step_q;
  logic              neg_q, signed_q, accum_q;
  logic              accept, run_done, fix_strobe;
  mag_sign_t         mag_a, mag_b;
  logic              unused_mag_bits;

  always_comb begin
    mag_a = operand_mag(MAX_W'(multiplicand), N, op_signed);
    mag_b = operand_mag(MAX_W'(multiplier), N, op_signed);
  end

  assign unused_mag_bits = ^{mag_a.mag[MAX_W-1:N], mag_b.mag[MAX_W-1:N]};

  // Exit once the bits still to be consumed are all zero, or the last bit has been used.
  assign run_done    = (mplier_q[N-1:1] == '0) || ((int'(step_q) + 1) >= N);
  assign fix_product = neg_q ? (-partial_q) : partial_q;
  assign accept      = in_valid & in_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    fix_strobe = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN:  if (run_done) state_next = FIX;
      FIX: begin
        fix_strobe = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      step_q    <= '0;
      neg_q     <= 1'b0;
      signed_q  <= 1'b0;
      accum_q   <= 1'b0;
      product   <= '0;
    end else begin
      if (accept) begin
        mcand_q   <= mag_a.mag[N-1:0];
        mplier_q  <= mag_b.mag[N-1:0];
        partial_q <= '0;
        step_q    <= '0;
        neg_q     <= mag_a.neg ^ mag_b.neg;
        signed_q  <= op_signed;
        accum_q   <= op_accumulate;
      end else if (state == RUN) begin
        if (mplier_q[0]) partial_q <= partial_q + ({{N{1'b0}}, mcand_q} << step_q);
        mplier_q <= mplier_q >> 1;
        step_q   <= step_q + STEP_W'(1);
      end
      if (fix_strobe) product <= fix_product;
    end
  end

  multiplier_mac_accumulator #(.N(N), .G(G)) u_acc (
    .clock         (clock),
    .reset         (reset),
    .fix_strobe    (fix_strobe),
    .op_signed     (signed_q),
    .op_accumulate (accum_q),
    .product       (fix_product),
    .acc           (acc),
    .acc_overflow  (acc_overflow)
  );

endmodule

// File: tb/tb_multiplier_mac.sv
// Directed bench for multiplier_mac (N=8, G=4): latency, signed/unsigned products,
// accumulation overflow, backpressure and mid-operation reset.
module tb_multiplier_mac;

  localparam int N     = 8;
  localparam int G     = 4;
  localparam int ACC_W = 2*N + G;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     multiplicand;
  logic [N-1:0]     multiplier;
  logic             op_signed;
  logic             op_accumulate;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   product;
  logic [ACC_W-1:0] acc;
  logic             acc_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  multiplier_mac #(.N(N), .G(G)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .op_signed     (op_signed),
    .op_accumulate (op_accumulate),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .product       (product),
    .acc           (acc),
    .acc_overflow  (acc_overflow)
  );

  // Issues one request and waits for out_valid; lat = edges from accept to out_valid.
  task automatic issue_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic s, input logic accum, output int lat);
    multiplicand  = a;
    multiplier    = b;
    op_signed     = s;
    op_accumulate = accum;
    in_valid      = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (product !== 16'h0) $display("FAIL reset_product: got %h want 0000", product);
    else n_pass++;
    n_checks++;
    if (acc !== 20'h0 || acc_overflow !== 1'b0)
      $display("FAIL reset_acc: got %h/%b want 00000/0", acc, acc_overflow);
    else n_pass++;
  endtask

  task automatic test_unsigned();
    int lat;
    issue_op(8'd200, 8'd150, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 9) $display("FAIL unsigned_latency: got %0d want 9", lat);
    else n_pass++;
    n_checks++;
    if (product !== 16'h7530) $display("FAIL unsigned_product: got %h want 7530", product);
    else n_pass++;
    n_checks++;
    if (acc !== 20'h07530) $display("FAIL unsigned_acc: got %h want 07530", acc);
    else n_pass++;
    handoff();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL handoff: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_signed();
    int lat;
    issue_op(8'hF9, 8'd5, 1'b1, 1'b0, lat);
    n_checks++;
    if (lat !== 4) $display("FAIL signed_latency: got %0d want 4", lat);
    else n_pass++;
    n_checks++;
    if (product !== 16'hFFDD) $display("FAIL signed_product: got %h want ffdd", product);
    else n_pass++;
    n_checks++;
    if (acc !== 20'hFFFDD) $display("FAIL signed_acc: got %h want fffdd", acc);
    else n_pass++;
    handoff();
  endtask

  task automatic test_boundaries();
    int lat;
    issue_op(8'hFF, 8'h00, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL zero_latency: got %0d want 2", lat);
    else n_pass++;
    n_checks++;
    if (product !== 16'h0 || acc !== 20'h0)
      $display("FAIL zero_product: got %h/%h want 0000/00000", product, acc);
    else n_pass++;
    handoff();
    issue_op(8'h80, 8'h80, 1'b1, 1'b0, lat);
    n_checks++;
    if (lat !== 9) $display("FAIL minsq_latency: got %0d want 9", lat);
    else n_pass++;
    n_checks++;
    if (product !== 16'h4000 || acc !== 20'h04000)
      $display("FAIL minsq_product: got %h/%h want 4000/04000", product, acc);
    else n_pass++;
    handoff();
  endtask

  task automatic test_accumulate();
    int lat;
    for (int op = 1; op <= 32; op++) begin
      issue_op(8'h80, 8'h80, 1'b1, (op != 1), lat);
      if (op == 31) begin
        n_checks++;
        if (acc !== 20'h7C000 || acc_overflow !== 1'b0)
          $display("FAIL acc_op31: got %h/%b want 7c000/0", acc, acc_overflow);
        else n_pass++;
      end
      if (op == 32) begin
        n_checks++;
        if (acc !== 20'h80000 || acc_overflow !== 1'b1)
          $display("FAIL acc_op32: got %h/%b want 80000/1", acc, acc_overflow);
        else n_pass++;
      end
      handoff();
    end
    issue_op(8'd2, 8'd3, 1'b0, 1'b0, lat);
    n_checks++;
    if (acc !== 20'h00006 || acc_overflow !== 1'b0)
      $display("FAIL acc_reload: got %h/%b want 00006/0", acc, acc_overflow);
    else n_pass++;
    handoff();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue_op(8'd3, 8'd3, 1'b0, 1'b0, lat);
    multiplicand = 8'd7;
    multiplier   = 8'd7;
    in_valid     = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'd9 || acc !== 20'd9)
        bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL backpressure_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
    in_valid = 1'b0;
    handoff();
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'd9)
      $display("FAIL backpressure_no_take: got out_valid=%b in_ready=%b product=%h want 0/1/0009",
               out_valid, in_ready, product);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    multiplicand  = 8'd200;
    multiplier    = 8'd150;
    op_signed     = 1'b0;
    op_accumulate = 1'b1;
    in_valid      = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc !== 20'h0)
      $display("FAIL mid_reset: got in_ready=%b out_valid=%b acc=%h want 1/0/00000",
               in_ready, out_valid, acc);
    else n_pass++;
    issue_op(8'd9, 8'd9, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 5 || product !== 16'h0051 || acc !== 20'h00051)
      $display("FAIL after_reset_op: got lat=%0d product=%h acc=%h want 5/0051/00051",
               lat, product, acc);
    else n_pass++;
    handoff();
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    multiplicand  = '0;
    multiplier    = '0;
    op_signed     = 1'b0;
    op_accumulate = 1'b0;
    out_ready     = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_boundaries();
    test_accumulate();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
